trng_byte_packer: RTL and testbench

Serial-to-byte packer between the ring-oscillator sampler and the 8-bit MDS diffusion stage of the post-processing chain. It accepts one raw random bit per qualified cycle and, optionally, debiases the bits with a von Neumann corrector. It packs the bits MSB-first into bytes and presents each byte to the diffusion stage through a valid/ready holding register. Bytes that complete while the holding register is still occupied are dropped and counted, never stalled, because the sampler cannot be back-pressured.

---
 rtl/trng_pp_pkg.sv | 9 +
 rtl/von_neumann_corrector.sv | 41 ++++
 rtl/trng_byte_packer.sv | 108 ++++++++++
 tb/tb_trng_byte_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pp_pkg.sv
// rtl/trng_pp_pkg.sv - shared constants and byte type for the TRNG post-processing chain
package trng_pp_pkg;

  localparam int PP_BYTE_W = 8;
  localparam int PP_BCNT_W = 3;

  typedef logic [PP_BYTE_W-1:0] pp_byte_t;

endpackage

// File: rtl/von_neumann_corrector.sv
// rtl/von_neumann_corrector.sv - von Neumann debiaser; pairs qualified bits, emits first bit of 01/10 pairs
module von_neumann_corrector (
  input  logic CLK,
  input  logic RST_N,
  input  logic BIT_IN,
  input  logic BIT_VALID,
  output logic VN_BIT,
  output logic VN_VALID
);

  logic half_q, half_d;
  logic flag_q, flag_d;

  always_comb begin
    half_d = half_q;
    flag_d = flag_q;
    if (BIT_VALID) begin
      if (!flag_q) begin
        half_d = BIT_IN;
        flag_d = 1'b1;
      end else begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      half_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      half_q <= half_d;
      flag_q <= flag_d;
    end
  end

  // Output is combinational so the emitted bit reaches the shifter in the same cycle.
  assign VN_BIT   = half_q;
  assign VN_VALID = BIT_VALID & flag_q & (half_q ^ BIT_IN);

endmodule

// File: rtl/trng_byte_packer.sv
// rtl/trng_byte_packer.sv - MSB-first bit-to-byte packer with drop-on-full holding register
// Optional debiasing enabled by defining TRNG_VON_NEUMANN_EN.
module trng_byte_packer
  import trng_pp_pkg::*;
#(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  BIT_IN,
  input  logic                  BIT_VALID,
  output pp_byte_t              D_OUT,
  output logic                  D_VALID,
  input  logic                  D_READY,
  output logic                  OVERFLOW,
  output logic [DROP_CNT_W-1:0] DROP_CNT,
  input  logic                  CLR_OVF
);

  localparam logic [PP_BCNT_W-1:0]  BCNT_ONE  = 1;
  localparam logic [PP_BCNT_W-1:0]  BCNT_LAST = '1;
  localparam logic [DROP_CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [DROP_CNT_W-1:0] CNT_MAX   = '1;

  logic acc_bit;
  logic acc_valid;

`ifdef TRNG_VON_NEUMANN_EN
  von_neumann_corrector u_vn (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .VN_BIT    (acc_bit),
    .VN_VALID  (acc_valid)
  );
`else
  assign acc_bit   = BIT_IN;
  assign acc_valid = BIT_VALID;
`endif

  // Only the seven oldest bits need storing; the eighth arrives with completion.
  logic [PP_BYTE_W-2:0]  sr_q, sr_d;
  logic [PP_BCNT_W-1:0]  bcnt_q, bcnt_d;
  pp_byte_t              d_out_q, d_out_d;
  logic                  d_valid_q, d_valid_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  complete, load, drop;

  always_comb begin
    complete   = acc_valid && (bcnt_q == BCNT_LAST);
    load       = complete && (!d_valid_q || D_READY);
    drop       = complete && !load;
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    d_out_d    = d_out_q;
    d_valid_d  = d_valid_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (acc_valid) begin
      sr_d   = {sr_q[PP_BYTE_W-3:0], acc_bit};
      bcnt_d = bcnt_q + BCNT_ONE;
    end

    if (load) begin
      d_out_d   = {sr_q, acc_bit};
      d_valid_d = 1'b1;
    end else if (d_valid_q && D_READY) begin
      d_valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear leaves a count of exactly one.
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = CLR_OVF ? CNT_ONE :
                   (drop_cnt_q == CNT_MAX) ? CNT_MAX : drop_cnt_q + CNT_ONE;
    end else if (CLR_OVF) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q       <= '0;
      bcnt_q     <= '0;
      d_out_q    <= '0;
      d_valid_q  <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign D_OUT    = d_out_q;
  assign D_VALID  = d_valid_q;
  assign OVERFLOW = ovf_q;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_trng_byte_packer.sv
// tb/tb_trng_byte_packer.sv - scoreboard bench for trng_byte_packer (raw or TRNG_VON_NEUMANN_EN build)
module tb_trng_byte_packer;
  import trng_pp_pkg::*;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          BIT_IN = 1'b0;
  logic          BIT_VALID = 1'b0;
  logic          D_READY = 1'b0;
  logic          CLR_OVF = 1'b0;
  pp_byte_t      D_OUT;
  logic          D_VALID;
  logic          OVERFLOW;
  logic [CW-1:0] DROP_CNT;

  int checks = 0;
  int errors = 0;

  bit           accq[$];
  byte unsigned expq[$];
  bit           m_valid, m_ovf, m_have, m_half;
  int           m_cnt;

  trng_byte_packer #(.DROP_CNT_W(CW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .D_OUT     (D_OUT),
    .D_VALID   (D_VALID),
    .D_READY   (D_READY),
    .OVERFLOW  (OVERFLOW),
    .DROP_CNT  (DROP_CNT),
    .CLR_OVF   (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: bits (after optional pairing) collect into a list; every eighth forms a byte.
  task automatic model_step(input bit bv, input bit b, input bit rdy, input bit clr);
    bit emit = 1'b0;
    bit eb = 1'b0;
    bit loaded = 1'b0;
    bit dropped = 1'b0;
    byte unsigned v = 0;
`ifdef TRNG_VON_NEUMANN_EN
    if (bv) begin
      if (!m_have) begin
        m_half = b;
        m_have = 1'b1;
      end else begin
        m_have = 1'b0;
        if (m_half != b) begin
          emit = 1'b1;
          eb = m_half;
        end
      end
    end
`else
    emit = bv;
    eb = b;
`endif
    if (emit) begin
      accq.push_back(eb);
      if (accq.size() == 8) begin
        for (int i = 0; i < 8; i++) v = (v << 1) | byte'(accq[i]);
        accq.delete();
        if (!m_valid || rdy) begin
          expq.push_back(v);
          loaded = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
    if (dropped) begin
      m_ovf = 1'b1;
      m_cnt = clr ? 1 : (m_cnt == CMAX ? CMAX : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic drive(input bit bv, input bit b, input bit rdy, input bit clr);
    BIT_VALID = bv;
    BIT_IN = b;
    D_READY = rdy;
    CLR_OVF = clr;
    model_step(bv, b, rdy, clr);
    @(posedge CLK);
    #1;
  endtask

  // In the debiased build each packed bit b is sent as the pair (b, ~b).
  task automatic send_bit(input bit b, input bit rdy, input bit clr);
`ifdef TRNG_VON_NEUMANN_EN
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b1, ~b, rdy, clr);
`else
    drive(1'b1, b, rdy, clr);
`endif
  endtask

  task automatic send_byte(input byte unsigned v, input bit rdy);
    for (int i = 7; i >= 0; i--) send_bit(v[i], rdy, 1'b0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_d_valid"}, D_VALID, m_valid);
    chk({tag, "_overflow"}, OVERFLOW, m_ovf);
    chk({tag, "_drop_cnt"}, DROP_CNT, m_cnt);
  endtask

  task automatic do_reset();
    BIT_VALID = 1'b0;
    D_READY = 1'b0;
    CLR_OVF = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_d_out", D_OUT, 0);
    chk("rst_d_valid", D_VALID, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_drop_cnt", DROP_CNT, 0);
    accq.delete();
    expq.delete();
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_have = 1'b0;
    m_half = 1'b0;
    m_cnt = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && D_VALID && D_READY) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %02h expected none", D_OUT);
        end else begin
          chk("sb_byte", D_OUT, expq.pop_front());
        end
      end
    end
  end

  initial begin
    byte unsigned v;
    @(posedge CLK);
    #1;
    do_reset();

    // Fill B2 with an always-ready sink.
    send_byte(8'hB2, 1'b1);
    chk("fill_d_out", D_OUT, 8'hB2);
    chk("fill_d_valid", D_VALID, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fill_cleared", D_VALID, 0);
    check_status("fill");

    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("bp_d_out", D_OUT, 8'hA5);
    chk("bp_overflow", OVERFLOW, 1);
    chk("bp_drop_cnt", DROP_CNT, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drained", D_VALID, 0);

    do_reset();
    send_byte(8'hF0, 1'b0);
    chk("dl_first", D_OUT, 8'hF0);
    v = 8'h0F;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0, 1'b0);
    send_bit(v[0], 1'b1, 1'b0);
    chk("dl_d_out", D_OUT, 8'h0F);
    chk("dl_d_valid", D_VALID, 1);
    chk("dl_no_drop", OVERFLOW, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef TRNG_VON_NEUMANN_EN
    do_reset();
    v = 8'h00;
    begin
      bit [19:0] pairs;
      pairs = 20'b01_11_10_00_10_01_10_10_01_10;
      for (int i = 19; i >= 0; i--) drive(1'b1, pairs[i], 1'b0, 1'b0);
    end
    chk("vn_d_out", D_OUT, 8'h6D);
    chk("vn_d_valid", D_VALID, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Five raw qualified bits leave a partial byte (and an odd half-pair when debiasing).
    do_reset();
    v = 8'h1D;
    for (int i = 4; i >= 0; i--) drive(1'b1, v[i], 1'b0, 1'b0);
    do_reset();
    send_byte(8'h81, 1'b0);
    chk("rmb_d_out", D_OUT, 8'h81);
    check_status("rmb");
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    do_reset();
    send_byte(8'h11, 1'b0);
    repeat ((1 << CW) + 3) send_byte(8'($urandom), 1'b0);
    chk("sat_drop_cnt", DROP_CNT, CMAX);
    chk("sat_overflow", OVERFLOW, 1);
    chk("sat_d_out", D_OUT, 8'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_cnt", DROP_CNT, 0);
    chk("clr_overflow", OVERFLOW, 0);
    v = 8'h55;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0, 1'b0);
    send_bit(v[0], 1'b0, 1'b1);
    chk("clrdrop_overflow", OVERFLOW, 1);
    chk("clrdrop_drop_cnt", DROP_CNT, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    do_reset();
    repeat (3000) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
      check_status("rnd");
    end
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_empty", expq.size(), 0);
    chk("end_d_valid", D_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
